// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO behind the UART receiver. Each rising edge of the receiver's
// frame-done level writes one byte. The head entry is shown ahead of the read.
module rx_byte_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              rx_ready_q;
    logic              ovf_q;

    logic push;
    logic pop;
    logic wr_ok;
    logic drop;

    // Status flags are decoded straight from the occupancy register
    always_comb begin
        empty      = (cnt_q == CNT_W'(0));
        full       = (cnt_q == CNT_W'(DEPTH));
        count      = cnt_q;
        dout_valid = !empty;
        overflow   = ovf_q;
        dout       = empty ? DATA_W'(0) : mem[rd_ptr];
    end

    // Edge detect on the receiver level. A write also goes through when full
    // if the head is popped in the same cycle (the freed slot is reused).
    always_comb begin
        push  = rx_ready & ~rx_ready_q;
        pop   = rd_en & !empty;
        wr_ok = push & (!full | pop);
        drop  = push & full & !pop;
    end

    // Byte storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers, occupancy and level history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            rx_ready_q <= 1'b1;
        end else begin
            rx_ready_q <= rx_ready;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_ok, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky drop flag; a drop beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo.
module tb_rx_byte_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rd_en;
    logic [7:0] dout;
    logic       dout_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q[$];
    logic [7:0] exp_b;

    rx_byte_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid), .empty(empty),
        .full(full), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One receiver frame: level rises for one cycle, then returns low
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with rx_ready held high across release
        rst = 1'b0; rx_ready = 1'b1; rx_data = 8'h33; rd_en = 1'b0; clr_ovf = 1'b0;
        #22;
        check("rst_count", 32'(count), 0);
        check("rst_dout", 32'(dout), 0);
        rst = 1'b1;
        repeat (100) tick();
        check("r1_count", 32'(count), 0);
        check("r1_empty", 32'(empty), 1);
        check("r1_valid", 32'(dout_valid), 0);
        check("r1_ovf", 32'(overflow), 0);
        check("r1_dout", 32'(dout), 0);

        // 2: single byte, long-held level gives one write
        rx_ready = 1'b0;
        tick();
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        #1;
        check("s2_valid_pre", 32'(dout_valid), 0);
        tick();
        check("s2_valid", 32'(dout_valid), 1);
        check("s2_dout", 32'(dout), 32'hA5);
        repeat (5000) tick();
        check("s2_count", 32'(count), 1);
        pop_one();
        check("s2_empty", 32'(empty), 1);
        check("s2_dout0", 32'(dout), 0);
        rx_ready = 1'b0;
        tick();

        // 3: fill, drop on full, drain in order
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check("f3_full", 32'(full), 1);
        check("f3_count", 32'(count), 16);
        send_byte(8'hFF);
        check("f3_ovf", 32'(overflow), 1);
        check("f3_count2", 32'(count), 16);
        check("f3_head", 32'(dout), 0);
        for (int i = 0; i < 16; i++) begin
            check("f3_drain", 32'(dout), 32'(i));
            pop_one();
        end
        check("f3_empty", 32'(empty), 1);
        check("f3_ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("f3_clr", 32'(overflow), 0);

        // 4: push and pop together while full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        check("p4_full", 32'(full), 1);
        rx_data = 8'h55; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rx_ready = 1'b0;
        tick();
        check("p4_count", 32'(count), 16);
        check("p4_ovf", 32'(overflow), 0);
        for (int i = 1; i < 16; i++) begin
            check("p4_drain", 32'(dout), 32'(8'h10 + i));
            pop_one();
        end
        check("p4_last", 32'(dout), 32'h55);
        pop_one();
        check("p4_empty", 32'(empty), 1);

        // 5: interleaved traffic across pointer wrap, plus ignored reads
        for (int i = 0; i < 40; i++) begin
            exp_b = 8'(i * 7 + 3);
            send_byte(exp_b);
            q.push_back(exp_b);
            if (q.size() == 3 || i == 39) begin
                while (q.size() != 0) begin
                    exp_b = q.pop_front();
                    check("w5_order", 32'(dout), 32'(exp_b));
                    pop_one();
                end
                pop_one();
                check("w5_idle_rd", 32'(count), 0);
            end
        end
        check("w5_empty", 32'(empty), 1);
        check("w5_dout0", 32'(dout), 0);
        // push into empty with rd_en asserted: push only
        rx_data = 8'h6C; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rx_ready = 1'b0;
        tick();
        check("w5_pe_count", 32'(count), 1);
        check("w5_pe_dout", 32'(dout), 32'h6C);
        // push and pop together when partly filled
        rx_data = 8'h7D; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rx_ready = 1'b0;
        tick();
        check("w5_pp_count", 32'(count), 1);
        check("w5_pp_dout", 32'(dout), 32'h7D);
        pop_one();

        // 6: clear vs drop priority, clear alone, async reset
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        rx_data = 8'hFF; rx_ready = 1'b1; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0; rx_ready = 1'b0;
        tick();
        check("c6_set_wins", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("c6_clr", 32'(overflow), 0);
        rd_en = 1'b1;
        repeat (16) tick();
        rd_en = 1'b0;
        check("c6_drained", 32'(empty), 1);
        for (int i = 0; i < 7; i++) send_byte(8'(8'h40 + i));
        check("c6_count7", 32'(count), 7);
        #2;
        rst = 1'b0;
        #1;
        check("c6_async_cnt", 32'(count), 0);
        check("c6_async_empty", 32'(empty), 1);
        check("c6_async_dout", 32'(dout), 0);
        #2;
        rst = 1'b1;
        tick();
        check("c6_post_cnt", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
